// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the pipelined LEGv8 core.
// Single outstanding imem request, one-entry skid buffer, redirect/flush.
module fetch_stage #(
  parameter int               N        = 64,
  parameter logic [N-1:0]     RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall_d,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [31:0]  instr_d,
  output logic [N-1:0] pc_d,
  output logic         valid_d
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_f_q, pc_f_d;
  logic         drop_q, drop_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [N-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [N-1:0] ifid_pc_q, ifid_pc_d;
  logic         ifid_vld_q, ifid_vld_d;

  logic         ifid_free, consume;
  logic [N-1:0] tgt;

  assign ifid_free = !ifid_vld_q || !stall_d;
  assign consume   = ifid_vld_q && !stall_d;
  assign tgt       = redirect_pc & ~N'(3);

  assign imem_addr = pc_f_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign valid_d   = ifid_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_f_q       <= RESET_PC;
      drop_q       <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      drop_q       <= drop_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  // Next state: redirect never leaves WAIT early, the in-flight ack must still be absorbed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!redirect) state_d = WAIT;
      WAIT: begin
        if (imem_ack) begin
          if (redirect || drop_q || ifid_free) state_d = IDLE;
          else                                 state_d = HOLD;
        end
      end
      HOLD:    if (redirect || !stall_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == IDLE) && !redirect && !reset;
  end

  always_comb begin
    pc_f_d       = pc_f_q;
    drop_d       = drop_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_vld_d   = ifid_vld_q;
    if (consume) ifid_vld_d = 1'b0;
    if (redirect) begin
      pc_f_d     = tgt;
      ifid_vld_d = 1'b0;
      drop_d     = (state_q == WAIT) && !imem_ack;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (imem_ack) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (ifid_free) begin
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = pc_f_q;
              ifid_vld_d   = 1'b1;
              pc_f_d       = pc_f_q + N'(4);
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_f_q;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            ifid_instr_d = skid_instr_q;
            ifid_pc_d    = skid_pc_q;
            ifid_vld_d   = 1'b1;
            pc_f_d       = pc_f_q + N'(4);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model of fetch order and delivered
// {pc, instr} pairs, directed scenarios, then randomized stall/redirect/latency.
module tb_fetch_stage;
  localparam int          N       = 64;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         imem_req, imem_ack, stall_d, redirect, valid_d;
  logic [N-1:0] imem_addr, redirect_pc, pc_d;
  logic [31:0]  imem_rdata, instr_d;

  logic         w_req, w_ack, w_valid;
  logic [N-1:0] w_addr, w_pc;
  logic [31:0]  w_rdata, w_instr;

  fetch_stage #(.N(N), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_d(instr_d),
    .pc_d(pc_d), .valid_d(valid_d)
  );

  fetch_stage #(.N(N), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall_d(1'b0),
    .redirect(1'b0), .redirect_pc(64'h0), .instr_d(w_instr),
    .pc_d(w_pc), .valid_d(w_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [63:0] a);
    if (a == 64'h0) return 32'hF84003E1;
    if (a == 64'h4) return 32'hF80003E2;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  // Reference: next address the program should fetch, next PC decode should consume.
  logic [63:0] fetch_exp, cons_exp, pend_addr, w_paddr;
  bit          pend, w_pend, inj_ack, rand_lat, rst_drv;
  int          cnt, lat, ncons;

  task automatic step(input bit st, input bit rd, input logic [63:0] rpc);
    @(negedge clk);
    reset       = rst_drv;
    stall_d     = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    if (inj_ack) begin
      imem_ack = 1'b1;
      inj_ack  = 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memw(pend_addr);
        pend       = 1'b0;
      end else cnt--;
    end
    w_ack   = w_pend;
    w_rdata = w_pend ? memw(w_paddr) : $urandom;
    w_pend  = 1'b0;
    #1;
    if (reset) begin
      pend = 1'b0; w_pend = 1'b0;
      fetch_exp = 64'h0; cons_exp = 64'h0;
      return;
    end
    if (valid_d && !stall_d) begin
      chk("cons_pc", pc_d, cons_exp);
      chk("cons_instr", instr_d, memw(pc_d));
      cons_exp += 64'd4;
      ncons++;
    end
    if (rd) begin
      chk("req_under_redirect", imem_req, 1'b0);
      fetch_exp = {rpc[63:2], 2'b00};
      cons_exp  = fetch_exp;
    end
    if (imem_req) begin
      chk("single_outstanding", pend, 1'b0);
      chk("req_addr", imem_addr, fetch_exp);
      fetch_exp += 64'd4;
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = rand_lat ? int'($urandom_range(0, 2)) : lat - 1;
    end
    if (w_req) begin
      w_pend  = 1'b1;
      w_paddr = w_addr;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, valid_d, 1'b0);
    chk({tag, "_instr"}, instr_d, 32'h0);
    chk({tag, "_pc"}, pc_d, 64'h0);
    chk({tag, "_req"}, imem_req, 1'b0);
  endtask

  initial begin
    stall_d = 0; redirect = 0; redirect_pc = '0; imem_ack = 0; imem_rdata = '0;
    w_ack = 0; w_rdata = '0;
    pend = 0; w_pend = 0; inj_ack = 0; rand_lat = 0; lat = 1; ncons = 0; cnt = 0;
    fetch_exp = 0; cons_exp = 0; pend_addr = 0; w_paddr = 0;
    rst_drv = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_reset("rst");
    chk("rst_addr", imem_addr, 64'h0);

    // Latency-1 streaming of the first two words; wrap instance runs alongside.
    rst_drv = 0;
    step(0, 0, 0);
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 64'h0);
    chk("t5_addr0", w_addr, WRAP_PC);
    step(0, 0, 0);
    chk("t1_ackcyc_valid", valid_d, 1'b0);
    step(0, 0, 0);
    chk("t1_valid0", valid_d, 1'b1);
    chk("t1_pc0", pc_d, 64'h0);
    chk("t1_instr0", instr_d, 32'hF84003E1);
    chk("t1_addr1", imem_addr, 64'h4);
    chk("t5_valid", w_valid, 1'b1);
    chk("t5_pc", w_pc, WRAP_PC);
    chk("t5_instr", w_instr, memw(WRAP_PC));
    chk("t5_addr_wrap", w_addr, 64'h0);
    chk("t5_req", w_req, 1'b1);
    step(0, 0, 0);
    chk("t1_bubble", valid_d, 1'b0);

    // Ack for 0x8 lands while IF/ID is stalled -> skid.
    step(1, 0, 0);
    chk("t1_valid1", valid_d, 1'b1);
    chk("t1_pc1", pc_d, 64'h4);
    chk("t1_instr1", instr_d, 32'hF80003E2);
    chk("t2_addr8", imem_addr, 64'h8);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t2_hold_noreq", imem_req, 1'b0);
    chk("t2_hold_pc", pc_d, 64'h4);
    step(0, 0, 0);
    chk("t2_release_noreq", imem_req, 1'b0);
    lat = 3;
    step(0, 0, 0);
    chk("t2_valid", valid_d, 1'b1);
    chk("t2_pc", pc_d, 64'h8);
    chk("t2_instr", instr_d, memw(64'h8));
    chk("t2_next_addr", imem_addr, 64'hC);

    // Redirect while waiting on a latency-3 fetch.
    step(0, 1, 64'h40);
    step(0, 0, 0);
    chk("t3_valid_a", valid_d, 1'b0);
    step(0, 0, 0);
    chk("t3_valid_b", valid_d, 1'b0);
    chk("t3_wait_noreq", imem_req, 1'b0);
    lat = 1;
    step(0, 0, 0);
    chk("t3_dropped", valid_d, 1'b0);
    chk("t3_req", imem_req, 1'b1);
    chk("t3_addr", imem_addr, 64'h40);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t3_valid", valid_d, 1'b1);
    chk("t3_pc", pc_d, 64'h40);
    chk("t3_instr", instr_d, memw(64'h40));

    // Redirect coincident with ack while stalled.
    step(1, 1, 64'h43);
    step(0, 0, 0);
    chk("t4_flush", valid_d, 1'b0);
    chk("t4_idle_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 64'h40);
    step(0, 0, 0);
    lat = 3;
    step(0, 0, 0);
    chk("t4_pc", pc_d, 64'h40);

    // Reset mid-transaction; a stale ack arrives in IDLE after release.
    rst_drv = 1;
    step(0, 0, 0);
    chk_reset("t6_rst");
    rst_drv = 0;
    inj_ack = 1;
    lat = 1;
    step(0, 1, 64'h0);
    step(0, 0, 0);
    chk("t6_stale", valid_d, 1'b0);
    chk("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, 64'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_valid", valid_d, 1'b1);
    chk("t6_pc", pc_d, 64'h0);

    rand_lat = 1;
    ncons = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, {$urandom, $urandom});
    chk("progress", ncons >= 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
